// File: rtl/arb_pkg.sv
// ============================================================================
// arb_pkg : types shared by the arbiter grant-dispatch stage
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package arb_pkg;

  // Arbiter geometry; arb_grant_dispatch must be built with these same values.
  localparam int ARB_VECTOR_IN = 8;
  localparam int ARB_DATA_W    = 64;
  localparam int ARB_IDX_W     = $clog2(ARB_VECTOR_IN);

  typedef logic [ARB_IDX_W-1:0] port_idx_t;

  typedef struct packed {
    logic [ARB_DATA_W-1:0] data;
    port_idx_t             port;
  } dispatch_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } disp_state_t;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/onehot_enc.sv
// ============================================================================
// onehot_enc : combinational one-hot to binary index encoder with legality flag
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module onehot_enc #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             is_onehot
);

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign is_onehot = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (vec[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule : onehot_enc

`default_nettype wire

// File: rtl/arb_grant_dispatch.sv
// ============================================================================
// arb_grant_dispatch : captures the arbiter winner's payload into a 2-entry
//                      skid buffer and dispatches it on a valid/ready port
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module arb_grant_dispatch
  import arb_pkg::*;
#(
  parameter int VECTOR_IN = ARB_VECTOR_IN,
  parameter int DATA_W    = ARB_DATA_W,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [VECTOR_IN-1:0]         request_vector,
  input  logic [VECTOR_IN-1:0]         grant,
  input  logic [DATA_W-1:0]            req_data [VECTOR_IN],
  output logic [VECTOR_IN-1:0]         ack,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(VECTOR_IN)-1:0] out_port,
  output logic                         err_grant,
  output logic [CNT_W-1:0]             dispatch_cnt
);

  disp_state_t     state_q, state_d;
  dispatch_entry_t head_q,  head_d;
  dispatch_entry_t next_q,  next_d;
  logic            err_q,   err_d;
  logic [CNT_W-1:0] cnt_q,  cnt_d;

  port_idx_t       grant_idx;
  logic            grant_onehot;
  logic            grant_valid;
  logic            grant_bad;
  logic            cap;
  logic            pop;
  dispatch_entry_t new_entry;

  onehot_enc #(
    .WIDTH (VECTOR_IN)
  ) u_onehot_enc (
    .vec       (grant),
    .idx       (grant_idx),
    .is_onehot (grant_onehot)
  );

  // A legal grant is one-hot and only hits a port that is actually requesting.
  assign grant_valid = grant_onehot && ((grant & request_vector) == grant);
  assign grant_bad   = (grant != '0) && !grant_valid;

  // Space is a function of registered state only: FULL never captures, even on pop.
  assign cap = grant_valid && (state_q != FULL) && reset;
  assign pop = out_valid && out_ready;
  assign ack = cap ? grant : '0;

  assign new_entry.data = req_data[grant_idx];
  assign new_entry.port = grant_idx;

  assign out_valid    = (state_q != EMPTY);
  assign out_data     = head_q.data;
  assign out_port     = head_q.port;
  assign err_grant    = err_q;
  assign dispatch_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    next_d  = next_q;
    err_d   = err_q | grant_bad;
    cnt_d   = cnt_q + CNT_W'(pop);

    case (state_q)
      EMPTY: begin
        if (cap) begin
          head_d  = new_entry;
          state_d = HALF;
        end
      end
      HALF: begin
        if (cap && !pop) begin
          next_d  = new_entry;
          state_d = FULL;
        end else if (cap && pop) begin
          head_d  = new_entry;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = next_q;
          state_d = HALF;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      next_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      next_q  <= next_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule : arb_grant_dispatch

`default_nettype wire

// File: tb/tb_arb_grant_dispatch.sv
// ============================================================================
// tb_arb_grant_dispatch : directed self-checking bench for arb_grant_dispatch
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_arb_grant_dispatch;

  localparam int VECTOR_IN = 8;
  localparam int DATA_W    = 64;
  localparam int CNT_W     = 4;

  logic                 clk;
  logic                 reset;
  logic [VECTOR_IN-1:0] request_vector;
  logic [VECTOR_IN-1:0] grant;
  logic [DATA_W-1:0]    req_data [VECTOR_IN];
  logic [VECTOR_IN-1:0] ack;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [2:0]           out_port;
  logic                 err_grant;
  logic [CNT_W-1:0]     dispatch_cnt;

  int n_total;
  int n_pass;

  arb_grant_dispatch #(
    .VECTOR_IN (VECTOR_IN),
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .request_vector (request_vector),
    .grant          (grant),
    .req_data       (req_data),
    .ack            (ack),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_port       (out_port),
    .err_grant      (err_grant),
    .dispatch_cnt   (dispatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] rv, input logic [7:0] gnt);
    request_vector = rv;
    grant          = gnt;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < VECTOR_IN; i++) req_data[i] = 64'h100 + 64'(i);
    out_ready = 1'b0;
    reset     = 1'b0;
    // Legal grant held during reset must not be acked.
    drive(8'h04, 8'h04);
    #2;
    check("rst_ack",       64'(ack),          64'h0);
    check("rst_out_valid", 64'(out_valid),    64'h0);
    check("rst_out_data",  out_data,          64'h0);
    check("rst_out_port",  64'(out_port),     64'h0);
    check("rst_err",       64'(err_grant),    64'h0);
    check("rst_cnt",       64'(dispatch_cnt), 64'h0);
    step();
    reset = 1'b1;

    // Single capture and pop
    drive(8'h04, 8'h04);
    req_data[2] = 64'hA5;
    out_ready   = 1'b1;
    #1;
    check("t1_ack", 64'(ack), 64'h04);
    step();
    drive(8'h00, 8'h00);
    check("t1_valid", 64'(out_valid), 64'h1);
    check("t1_data",  out_data,       64'hA5);
    check("t1_port",  64'(out_port),  64'h2);
    step();
    check("t1_cnt",   64'(dispatch_cnt), 64'h1);
    check("t1_empty", 64'(out_valid),    64'h0);

    // Fill under backpressure, third grant blocked
    out_ready = 1'b0;
    drive(8'h02, 8'h02);
    #1;
    check("t2_ack_p1", 64'(ack), 64'h02);
    step();
    drive(8'h08, 8'h08);
    #1;
    check("t2_ack_p3", 64'(ack), 64'h08);
    step();
    drive(8'h20, 8'h20);
    #1;
    check("t2_ack_p5_blocked", 64'(ack),       64'h00);
    check("t2_full_valid",     64'(out_valid), 64'h1);
    check("t2_head_stable",    64'(out_port),  64'h1);
    step();
    check("t2_hold_port", 64'(out_port), 64'h1);
    check("t2_hold_data", out_data,      64'h101);
    drive(8'h00, 8'h00);
    out_ready = 1'b1;
    step();
    check("t2_second_port", 64'(out_port), 64'h3);
    check("t2_second_data", out_data,      64'h103);
    step();
    check("t2_cnt",   64'(dispatch_cnt), 64'h3);
    check("t2_empty", 64'(out_valid),    64'h0);

    // Sustained one capture and one pop per cycle
    for (int k = 0; k < 10; k++) begin
      req_data[k % 8] = 64'hC000 + 64'(k);
      drive(8'(1 << (k % 8)), 8'(1 << (k % 8)));
      #1;
      check($sformatf("t3_ack_%0d", k), 64'(ack), 64'(1 << (k % 8)));
      step();
      check($sformatf("t3_valid_%0d", k), 64'(out_valid), 64'h1);
      check($sformatf("t3_data_%0d", k),  out_data,       64'hC000 + 64'(k));
    end
    drive(8'h00, 8'h00);
    step();
    check("t3_cnt",   64'(dispatch_cnt), 64'd13);
    check("t3_empty", 64'(out_valid),    64'h0);

    // Malformed grants
    drive(8'h06, 8'h06);
    #1;
    check("t4_ack_multi", 64'(ack),       64'h0);
    check("t4_err_pre",   64'(err_grant), 64'h0);
    step();
    check("t4_err_set",   64'(err_grant), 64'h1);
    check("t4_no_cap1",   64'(out_valid), 64'h0);
    drive(8'h01, 8'h10);
    #1;
    check("t4_ack_noreq", 64'(ack), 64'h0);
    step();
    check("t4_no_cap2", 64'(out_valid), 64'h0);
    req_data[0] = 64'hDEAD;
    drive(8'h01, 8'h01);
    #1;
    check("t4_ack_legal", 64'(ack), 64'h01);
    step();
    drive(8'h00, 8'h00);
    check("t4_data",       out_data,          64'hDEAD);
    check("t4_err_sticky", 64'(err_grant),    64'h1);
    step();
    check("t4_cnt",        64'(dispatch_cnt), 64'd14);
    check("t4_err_still",  64'(err_grant),    64'h1);

    // Counter wrap at 2^CNT_W
    for (int k = 0; k < 2; k++) begin
      drive(8'h10, 8'h10);
      step();
      drive(8'h00, 8'h00);
      step();
      check($sformatf("t5_cnt_%0d", k), 64'(dispatch_cnt), (k == 0) ? 64'd15 : 64'd0);
    end

    // Asynchronous reset while FULL and stalled
    out_ready = 1'b0;
    drive(8'h02, 8'h02);
    step();
    drive(8'h04, 8'h04);
    step();
    drive(8'h08, 8'h08);
    check("t6_full_valid", 64'(out_valid), 64'h1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid),    64'h0);
    check("t6_rst_cnt",   64'(dispatch_cnt), 64'h0);
    check("t6_rst_err",   64'(err_grant),    64'h0);
    check("t6_rst_data",  out_data,          64'h0);
    check("t6_rst_ack",   64'(ack),          64'h0);
    step();
    reset       = 1'b1;
    req_data[5] = 64'h5555;
    out_ready   = 1'b1;
    drive(8'h20, 8'h20);
    #1;
    check("t6_ack", 64'(ack), 64'h20);
    step();
    drive(8'h00, 8'h00);
    check("t6_port", 64'(out_port), 64'h5);
    check("t6_data", out_data,      64'h5555);
    step();
    check("t6_cnt",  64'(dispatch_cnt), 64'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_arb_grant_dispatch

`default_nettype wire
